// File: rtl/demux_burst_scheduler.sv
// Burst scheduler for a 1-to-4 demux: routes a valid/ready stream to channels y0..y3
// in round-robin bursts of BURST beats, skipping disabled channels.
module demux_burst_scheduler #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ch_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             s1,
  output logic             s0,
  output logic             busy
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]       state;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data_q;
  logic             out_valid;

  logic [2:0]       nxt;
  logic             found;
  logic             drain;
  logic             accept;

  // Round-robin search starting after sel; the current channel is tried last.
  // Returns {found, channel}.
  function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] c;
    pick_next = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      c = cur + 2'(i);
      if (en[c]) pick_next = {1'b1, c};
    end
  endfunction

  assign nxt      = pick_next(sel, ch_en);
  assign found    = nxt[2];
  assign drain    = out_valid && y_ready[sel];
  assign in_ready = (state == ST_STREAM) && (!out_valid || y_ready[sel]);
  assign accept   = in_valid && in_ready;

  // Control: state, channel select and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 2'b11;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            sel   <= nxt[1:0];
            cnt   <= '0;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (cnt == LAST_BEAT) state <= ST_SWITCH;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          // Select lines may only move once the holding register is empty.
          if (!out_valid || drain) begin
            if (found) begin
              sel   <= nxt[1:0];
              cnt   <= '0;
              state <= ST_STREAM;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register: accept overrides drain so back-to-back beats flow without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      data_q    <= in_data;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign y_valid = out_valid ? (4'b0001 << sel) : 4'b0000;
  assign y0      = y_valid[0] ? data_q : '0;
  assign y1      = y_valid[1] ? data_q : '0;
  assign y2      = y_valid[2] ? data_q : '0;
  assign y3      = y_valid[3] ? data_q : '0;
  assign s1      = sel[1];
  assign s0      = sel[0];
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Scoreboard bench for demux_burst_scheduler: a burst-level reference model predicts
// the channel of every accepted beat; a monitor checks each drained beat in order.
module tb_demux_burst_scheduler;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       ch_en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       y_valid;
  logic [3:0]       y_ready;
  logic             s1, s0;
  logic             busy;

  demux_burst_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y_valid(y_valid),
    .y_ready(y_ready), .s1(s1), .s0(s0), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       ch;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: current burst channel and beats left in it
  int         m_ch = 3;
  int         m_left = 0;
  logic [3:0] forbid = 4'b0000;
  int         bad_vld = 0;
  logic [7:0] cur;

  bit         prev_acc = 0;
  int         prev_ch;
  logic [7:0] prev_d;
  bit         prev_stall = 0;
  int         ps_ch;
  logic [7:0] ps_d;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] yk(input int k);
    case (k)
      0: yk = y0;
      1: yk = y1;
      2: yk = y2;
      default: yk = y3;
    endcase
  endfunction

  function automatic int next_ch(input int c, input logic [3:0] en);
    for (int i = 1; i <= 4; i++)
      if (en[(c + i) % 4]) return (c + i) % 4;
    return c;
  endfunction

  // Monitor: samples mid-cycle, checks drains and predicts new beats
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ch = 3;
      m_left = 0;
      prev_acc = 0;
      prev_stall = 0;
    end else begin
      chk("onehot_y_valid", 32'($countones(y_valid) <= 1), 32'd1);
      if ((y_valid & forbid) != 4'b0000) bad_vld++;
      for (int k = 0; k < 4; k++)
        if (!y_valid[k]) chk($sformatf("idle_y%0d_zero", k), 32'(yk(k)), 32'd0);
      if (prev_acc) begin
        chk("latency_valid", 32'(y_valid[prev_ch]), 32'd1);
        chk("latency_data", 32'(yk(prev_ch)), 32'(prev_d));
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(y_valid[ps_ch]), 32'd1);
        chk("hold_data", 32'(yk(ps_ch)), 32'(ps_d));
      end
      prev_stall = 0;
      for (int k = 0; k < 4; k++) begin
        if (y_valid[k]) begin
          chk("select_lines", 32'({s1, s0}), 32'(k));
          if (!y_ready[k]) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            prev_stall = 1;
            ps_ch = k;
            ps_d = yk(k);
          end else if (sb.size() == 0) begin
            chk("unexpected_beat", 32'(yk(k)), 32'hFFFF);
          end else begin
            ent_t e;
            e = sb.pop_front();
            chk("beat_channel", 32'(k), 32'(e.ch));
            chk("beat_data", 32'(yk(k)), 32'(e.d));
          end
        end
      end
      prev_acc = 0;
      if (in_valid && in_ready) begin
        ent_t e;
        if (m_left == 0) begin
          m_ch = next_ch(m_ch, ch_en);
          m_left = BURST;
        end
        m_left--;
        e.ch = 2'(m_ch);
        e.d = in_data;
        sb.push_back(e);
        prev_acc = 1;
        prev_ch = m_ch;
        prev_d = in_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_y_valid"}, 32'(y_valid), 32'd0);
    chk({tag, "_y_all"}, 32'({y0, y1, y2, y3}), 32'd0);
    chk({tag, "_sel"}, 32'({s1, s0}), 32'd3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int n, input bit rnd, output int gaps);
    int i = 0;
    int cyc = 0;
    gaps = 0;
    while (i < n && cyc < 400) begin
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = rnd ? 8'($urandom) : cur;
      if (rnd) y_ready = 4'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
        cur++;
      end else if (i > 0) begin
        gaps++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("send_count", 32'(i), 32'(n));
  endtask

  task automatic drain_check(input string tag);
    y_ready = 4'b1111;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    ch_en = 4'($urandom);
    in_valid = 1'b1;
    in_data = 8'($urandom);
    y_ready = 4'($urandom);
    cur = 8'h00;

    // Reset with random inputs
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      ch_en = 4'($urandom); in_data = 8'($urandom); y_ready = 4'($urandom);
      #2 check_reset_outputs("reset");
    end
    ch_en = 4'b0000; in_valid = 1'b0; y_ready = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;

    // Full rotation
    ch_en = 4'b1111; cur = 8'h00;
    send(16, 0, g);
    chk("rotation_gaps", 32'(g), 32'd3);
    cur = 8'h10;
    send(1, 0, g);
    drain_check("rotation");

    // Skip disabled channels
    do_reset();
    ch_en = 4'b0101; y_ready = 4'b1111; cur = 8'h00; forbid = 4'b1010; bad_vld = 0;
    send(16, 0, g);
    drain_check("skip");
    chk("skip_forbidden_valid", 32'(bad_vld), 32'd0);
    forbid = 4'b0000;

    // Backpressure on y1 holding 0x05
    do_reset();
    ch_en = 4'b1111; y_ready = 4'b1111; cur = 8'h00;
    send(6, 0, g);
    y_ready = 4'b1101; in_valid = 1'b1; in_data = 8'h06;
    repeat (5) begin
      @(negedge clk);
      chk("bp_y1", 32'(y1), 32'h05);
      chk("bp_valid", 32'(y_valid), 32'b0010);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    y_ready = 4'b1111; cur = 8'h06;
    send(2, 0, g);
    drain_check("backpressure");

    // Mid-burst disable during y2 burst, then enable only y3
    do_reset();
    ch_en = 4'b1111; y_ready = 4'b1111; cur = 8'h00;
    send(10, 0, g);
    ch_en = 4'b0000;
    send(2, 0, g);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("disable_busy", 32'(busy), 32'd0);
    chk("disable_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    ch_en = 4'b1000; cur = 8'h20;
    send(4, 0, g);
    drain_check("reenable");

    // Asynchronous reset while a beat is held
    do_reset();
    ch_en = 4'b1111; y_ready = 4'b1111; cur = 8'h40;
    send(2, 0, g);
    chk("pre_reset_valid", 32'(y_valid), 32'b0001);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 8'h50;
    send(4, 0, g);
    drain_check("after_async_reset");

    // Randomized traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ch_en = 4'($urandom_range(1, 15));
      send(24, 1, g);
      drain_check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_burst_scheduler.md
# demux_burst_scheduler

Sequential controller for the 1-to-4 demultiplexer path. It accepts a single valid/ready input stream and distributes it in fixed-length bursts to four output channels, y0..y3, in round-robin order. It skips channels whose enable bit is clear and drives the demux select lines s1/s0 for the active channel. It sits between the upstream stream source and the four downstream consumers, and owns all sequencing of the select lines.

## Interface
- WIDTH, 8: data width of input and of each output channel.
- BURST, 4: beats delivered to one channel before advancing; legal range 1..256.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ch_en  input  4  per-channel enable; bit k enables channel yk.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  input beat data.
- in_ready  output  1  block accepts the beat this cycle.
- y0, y1, y2, y3  output  WIDTH  channel data; 0 when the channel is not selected or holds no valid beat.
- y_valid  output  4  bit k = beat valid on yk; at most one bit set.
- y_ready  input  4  bit k = consumer k accepts this cycle.
- s1, s0  output  1 each  registered select of the active channel, {s1,s0} = channel index.
- busy  output  1  high in STREAM or SWITCH.

## Operation
- Uses one output holding register: data_q and out_valid. The beat is accepted on in_valid && in_ready, and drained on out_valid && y_ready[sel].
- Beat counter cnt runs 0..BURST-1. It increments on each accepted input beat and clears on channel selection.
- States:
  - IDLE:
    - in_ready=0.
    - If ch_en != 0, select the next channel and go to STREAM. Otherwise stay.
  - STREAM:
    - in_ready = !out_valid || y_ready[sel].
    - An accepted beat with cnt == BURST-1 goes to SWITCH.
  - SWITCH:
    - in_ready=0.
    - Wait until the holding register is empty, or drains this cycle.
    - Then select the next channel and go to STREAM. If ch_en == 0, go to IDLE.
- Channel selection:
  - The search starts at (sel+1) mod 4 and wraps. The current channel is checked last, so a single enabled channel is reselected.
  - The first enabled channel found becomes sel, and cnt is cleared.
- ch_en is sampled only at selection. Clearing an enable mid-burst does not cut the burst; the change takes effect at the next selection.
- Output mapping: yk = data_q and y_valid[k] = out_valid when sel == k. Otherwise yk = 0 and y_valid[k] = 0.
- Holding register and backpressure:
  - data_q is held stable while out_valid && !y_ready[sel].
  - A simultaneous drain and accept in STREAM replaces data_q in the same cycle, with no bubble.
- Reset, asynchronous with rst_n low:
  - State → IDLE, sel = 2'b11 (s1=1, s0=1), so the first selection after reset is channel 0.
  - cnt=0, out_valid=0, data_q=0.
  - Outputs: in_ready=0, busy=0, y_valid=0, y0..y3 = 0.
  - A beat in flight when reset asserts is discarded.

## Timing
- Accepted input beat → y_valid on the selected channel: the next cycle (1-cycle latency).
- Within a burst with y_ready held high: 1 beat per cycle.
- IDLE → STREAM: 1 cycle after ch_en becomes nonzero. The select lines update on the same edge as the state change.
- Burst boundary: at least 1 SWITCH cycle with in_ready=0. If the last beat drains in that cycle, the next burst's first beat is accepted the following cycle.
- s1/s0 change only on the SWITCH→STREAM or IDLE→STREAM edge. They never change while out_valid=1.
- BURST=1: every accepted beat causes a SWITCH.

## Test plan
- Reset: hold rst_n=0 with random inputs.
  - Required: in_ready=0, y_valid=0000, y0..y3=0, {s1,s0}=11, busy=0.
  - Releasing reset with ch_en=0000 keeps the block in IDLE.
- Full rotation: BURST=4, ch_en=1111, y_ready=1111, continuous in_data 0x00..0x0F.
  - Required: y0 gets 00..03, y1 04..07, y2 08..0B, y3 0C..0F.
  - Exactly one in_ready=0 cycle between bursts; the next burst returns to y0.
- Skip disabled channels: ch_en=0101, same stream.
  - Required: bursts alternate y0, y2, y0, y2.
  - y_valid[1] and y_valid[3] never assert.
- Backpressure: y_ready[1]=0 for 5 cycles after the second beat of the y1 burst.
  - Required: y1 holds 0x05 stable and in_ready=0 throughout.
  - After release, 0x06 and 0x07 follow with no loss and no duplication.
- Mid-burst disable: ch_en 1111 → 0000 during the y2 burst.
  - Required: y2 still receives all 4 beats, then the block enters IDLE with busy=0.
  - Re-enabling ch_en=1000 selects y3.
- Async reset mid-burst: pull rst_n low between clock edges while out_valid=1.
  - Required: outputs reach their reset values immediately, without waiting for a clock edge.
  - After release, the first burst goes to y0 with cnt restarted at 0.
